// File: rtl/priority_scanner_pkg.sv
// Shared types and constants for the priority scanner: FSM state encoding
// and the scan-order mode values.
package priority_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_MSB_FIRST = 1'b0;
  localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/prio_find.sv
// Stateless priority encoder: picks the highest (or lowest) set bit of vec
// and flags whether vec is non-zero and whether it has at most one bit set.
module prio_find #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             lsb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  // Later loop iterations overwrite earlier hits, so loop direction picks the winner.
  always_comb begin
    idx = '0;
    if (lsb_first) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = i[IDX_W-1:0];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = i[IDX_W-1:0];
      end
    end
  end

  assign any    = |vec;
  assign single = ~|(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/priority_scanner.sv
// Accepts a request vector and emits one beat per set bit in priority order
// (MSB- or LSB-first); an all-zero vector yields a single flagged beat.
module priority_scanner
  import priority_scanner_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_zero,
  output logic             out_last,
  output logic [IDX_W:0]   out_count
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic             mode;
  logic [IDX_W-1:0] find_idx;
  logic             find_any;
  logic             find_single;

  // Beat counter saturates at WIDTH so it can never wrap.
  function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  endfunction

  prio_find #(
    .WIDTH(WIDTH)
  ) u_prio_find (
    .vec      (pending),
    .lsb_first(mode == MODE_LSB_FIRST),
    .idx      (find_idx),
    .any      (find_any),
    .single   (find_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // In SCAN pending is only empty when the accepted vector was all-zero,
  // since the last real bit sends the FSM back to IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_zero  = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = find_idx;
        out_zero  = ~find_any;
        out_last  = find_single;
        if (out_ready && find_single) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      mode      <= MODE_MSB_FIRST;
      out_count <= '0;
    end else if (in_valid && in_ready) begin
      pending   <= in_vec;
      mode      <= in_lsb_first;
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      pending   <= pending & ~(WIDTH'(1) << out_index);
      out_count <= sat_inc(out_count);
    end
  end

endmodule

// File: doc/priority_scanner.md
PRIORITY_SCANNER -- requirements
Module: priority_scanner

Interface
REQ-001 Parameter WIDTH, default 16, meaning request-vector width; legal range 2..256.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), meaning index width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request vector offered.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_vec  input  WIDTH  request vector; bit WIDTH-1 is MSB.
REQ-008 in_lsb_first  input  1  scan order, sampled with in_vec: 0 = MSB first, 1 = LSB first.
REQ-009 out_valid  output  1  out_index beat is valid.
REQ-010 out_ready  input  1  consumer accepts the current beat.
REQ-011 out_index  output  IDX_W  index of the currently selected set bit.
REQ-012 out_zero  output  1  accepted vector was all-zero.
REQ-013 out_last  output  1  final beat for the current vector.
REQ-014 out_count  output  IDX_W+1  number of beats already accepted for the current vector.

Function
REQ-015 The block SHALL have two states: IDLE and SCAN.
REQ-016 IDLE: in_ready SHALL be 1 and out_valid 0.
REQ-017 Input acceptance occurs when in_valid and in_ready are both 1. The block SHALL then register in_vec into pending and in_lsb_first into mode, clear out_count, and enter SCAN.
REQ-018 First out_valid SHALL rise exactly one cycle after acceptance.
REQ-019 SCAN: in_ready SHALL be 0, out_valid 1.
REQ-020 SCAN index selection:
- mode 0: out_index SHALL be the highest set bit of pending.
- mode 1: out_index SHALL be the lowest set bit of pending.
REQ-021 out_last SHALL be 1 when pending has at most one set bit.
REQ-022 Beat acceptance occurs when out_valid and out_ready are both 1. The block SHALL then clear bit out_index in pending and increment out_count. If out_last is 1, it SHALL return to IDLE.
REQ-023 Zero vector: when the accepted vector is all-zero, the block SHALL emit exactly one beat with out_zero=1, out_index=0, out_last=1.
REQ-024 out_zero SHALL be 0 on every beat of a non-zero vector.
REQ-025 While out_valid=1 and out_ready=0, out_index, out_zero, out_last and out_count SHALL hold stable.
REQ-026 out_count SHALL never wrap; its maximum value is WIDTH, reached after the last beat of an all-ones vector.
REQ-027 in_vec and in_lsb_first SHALL be ignored outside acceptance cycles. A vector change during SCAN SHALL not affect pending.
REQ-028 Back-to-back operation: after the last beat, in_ready SHALL be 1 in the following cycle. The minimum period for a vector with k set bits is k+1 cycles (1+1 for zero).

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force IDLE, with pending=0, mode=0, out_count=0.
REQ-030 In reset, outputs SHALL be: in_ready=1, out_valid=0, out_index=0, out_zero=0, out_last=0.
REQ-031 Reset asserted mid-SCAN SHALL discard the vector. No further beats for it SHALL appear after rst_n releases.

Structure
REQ-032 Package priority_scanner_pkg SHALL hold the state enum (IDLE, SCAN) and the mode constants MODE_MSB_FIRST=0 and MODE_LSB_FIRST=1.
REQ-033 One combinational sub-module SHALL be used: prio_find. It is parametrised by WIDTH and takes vec and lsb_first as inputs. It outputs idx, any (vector non-zero) and single (at most one bit set).
REQ-034 All registers SHALL reside in priority_scanner; prio_find SHALL contain no state.

Verification (WIDTH=16)
REQ-035 Vector 0x8001, in_lsb_first=0, out_ready=1: beats SHALL be idx 15 (last=0, count 0), then idx 0 (last=1, count 1); in_ready SHALL return 1 the next cycle.
REQ-036 Vector 0x8001, in_lsb_first=1: beat order SHALL be 0 then 15.
REQ-037 Vector 0x0000: exactly one beat with out_zero=1, out_index=0, out_last=1; then IDLE.
REQ-038 Vector 0xFFFF, MSB first, out_ready toggling 1/0 each cycle:
- 16 beats, indices 15 down to 0, outputs stable during stalls.
- out_count reaches 16 after the final beat.
REQ-039 Vector 0x00F0: rst_n pulsed low after the first accepted beat. out_valid SHALL drop immediately and in_ready SHALL be 1. After release, vector 0x0002 SHALL yield a single beat with idx 1.
REQ-040 in_vec changed to 0xFFFF during SCAN of 0x0003: beats SHALL be idx 1 and 0 only.
